// File: rtl/conv_mac_nd.sv
// rtl/conv_mac_nd.sv - multi-channel KxK convolution MAC with runtime weights/bias, ReLU and saturation
//
// Produces one output pixel per accepted window:
//   out = post( (sum_{e<N} in_data[e]*weight[e] + bias) >>> SHIFT )
// where post() optionally applies ReLU and/or saturation to OW bits.
// Latency is $clog2(N)+2 cycles, one sample per cycle, no backpressure.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid             window present on in_data this cycle
//   in_data              N packed signed DW-bit elements, e = c*K*K + r*K + col
//   relu_en, sat_en      per-sample post-processing selects (travel with the sample)
//   w_we, w_addr, w_data weight file write port; w_addr >= N is ignored
//   b_we, b_data         bias write port; only legal with the pipeline empty
//   out_valid            one-cycle pulse per result
//   out_data             signed result, held between pulses
//   sat_cnt              count of clamped results, sticks at 0xFFFF
module conv_mac_nd #(
   parameter int CH    = 3,
   parameter int K     = 5,
   parameter int DW    = 12,
   parameter int WW    = 8,
   parameter int OW    = 14,
   parameter int SHIFT = 10
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            in_valid,
   input  logic [CH*K*K*DW-1:0]            in_data,
   input  logic                            relu_en,
   input  logic                            sat_en,
   input  logic                            w_we,
   input  logic [$clog2(CH*K*K)-1:0]       w_addr,
   input  logic [WW-1:0]                   w_data,
   input  logic                            b_we,
   input  logic [DW+WW+$clog2(CH*K*K)-1:0] b_data,
   output logic                            out_valid,
   output logic [OW-1:0]                   out_data,
   output logic [15:0]                     sat_cnt
);

   localparam int N     = CH*K*K;
   localparam int D     = $clog2(N);
   localparam int ACC_W = DW + WW + D;
   localparam int PW    = DW + WW;
   localparam int NP    = 1 << D;

   localparam logic signed [ACC_W:0] RES_MAX = (ACC_W+1)'((2**(OW-1)) - 1);
   localparam logic signed [ACC_W:0] RES_MIN = (ACC_W+1)'(-(2**(OW-1)));

   // ------------------------------------------------------------------
   // Weight file and bias register
   // ------------------------------------------------------------------
   logic signed [WW-1:0]    w_q [N];
   logic signed [ACC_W-1:0] bias_q;

   // Addresses >= N match no entry, so those writes fall away naturally.
   for (genvar e = 0; e < N; e++) begin : g_wfile
      always_ff @(posedge clk) begin
         if (rst) begin
            w_q[e] <= '0;
         end else if (w_we && (w_addr == D'(e))) begin
            w_q[e] <= w_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bias_q <= '0;
      end else if (b_we) begin
         bias_q <= b_data;
      end
   end

   // ------------------------------------------------------------------
   // Stage 1 products, padded with zeros up to a power of two so the
   // tree below is a complete binary tree.  A zero partner makes an odd
   // last term pass straight through its level.
   // ------------------------------------------------------------------
   logic signed [ACC_W-1:0] prod_d [NP];

   for (genvar e = 0; e < NP; e++) begin : g_prod
      if (e < N) begin : g_real
         assign prod_d[e] = ACC_W'(PW'($signed(in_data[e*DW +: DW])) * PW'(w_q[e]));
      end else begin : g_pad
         assign prod_d[e] = '0;
      end
   end

   // ------------------------------------------------------------------
   // Adder tree stored heap-style: node i sums children 2i+1 and 2i+2,
   // leaves NP-1.. hold the registered products in index order, so
   // adjacent terms pair up level by level.  Root node 0 is ready D
   // cycles after the leaves.
   // ------------------------------------------------------------------
   logic signed [ACC_W-1:0] node_q [2*NP-1];

   for (genvar e = 0; e < NP; e++) begin : g_leaf
      always_ff @(posedge clk) begin
         node_q[NP-1+e] <= prod_d[e];
      end
   end

   for (genvar i = 0; i < NP-1; i++) begin : g_add
      always_ff @(posedge clk) begin
         node_q[i] <= node_q[2*i+1] + node_q[2*i+2];
      end
   end

   // ------------------------------------------------------------------
   // Per-sample control travelling alongside the data (index 0 = stage 1)
   // ------------------------------------------------------------------
   logic [D:0] vld_q;
   logic [D:0] relu_q;
   logic [D:0] sat_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= '0;
      end else begin
         vld_q <= {vld_q[D-1:0], in_valid};
      end
      relu_q <= {relu_q[D-1:0], relu_en};
      sat_q  <= {sat_q[D-1:0], sat_en};
   end

   // ------------------------------------------------------------------
   // Output stage: bias, floor shift, ReLU, saturation / wrap
   // ------------------------------------------------------------------
   logic                    out_valid_q, out_valid_d;
   logic [OW-1:0]           out_data_q, out_data_d;
   logic [15:0]             sat_cnt_q, sat_cnt_d;
   logic signed [ACC_W:0]   acc_d;
   logic signed [ACC_W:0]   res_d;
   logic                    clamp_d;

   always_comb begin
      acc_d       = {node_q[0][ACC_W-1], node_q[0]} + {bias_q[ACC_W-1], bias_q};
      res_d       = acc_d >>> SHIFT;
      clamp_d     = 1'b0;
      out_valid_d = vld_q[D];
      out_data_d  = out_data_q;
      sat_cnt_d   = sat_cnt_q;

      if (relu_q[D] && (res_d < 0)) begin
         res_d = '0;
      end

      if (sat_q[D] && (res_d > RES_MAX)) begin
         res_d   = RES_MAX;
         clamp_d = 1'b1;
      end else if (sat_q[D] && (res_d < RES_MIN)) begin
         res_d   = RES_MIN;
         clamp_d = 1'b1;
      end

      if (vld_q[D]) begin
         out_data_d = res_d[OW-1:0];
         if (clamp_d && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_d = sat_cnt_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         sat_cnt_q   <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         sat_cnt_q   <= sat_cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign sat_cnt   = sat_cnt_q;

endmodule

// File: tb/tb_conv_mac_nd.sv
// tb/tb_conv_mac_nd.sv - scoreboard testbench for conv_mac_nd
//
// Stimulus tasks compute each sample's expected result from a plain
// arithmetic model (weight/bias arrays, integer sum, floor shift, clamp)
// and queue it; an independent monitor pops on every out_valid.
module tb_conv_mac_nd;

   localparam int CH    = 3;
   localparam int K     = 5;
   localparam int DW    = 12;
   localparam int WW    = 8;
   localparam int OW    = 14;
   localparam int SHIFT = 10;
   localparam int N     = CH*K*K;
   localparam int AW    = $clog2(N);
   localparam int ACC_W = DW + WW + AW;
   localparam int LAT   = AW + 2;
   localparam longint OMAX = (64'sd1 <<< (OW-1)) - 1;
   localparam longint OMIN = -(64'sd1 <<< (OW-1));

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              in_valid = 1'b0;
   logic [N*DW-1:0]   in_data = '0;
   logic              relu_en = 1'b0;
   logic              sat_en = 1'b0;
   logic              w_we = 1'b0;
   logic [AW-1:0]     w_addr = '0;
   logic [WW-1:0]     w_data = '0;
   logic              b_we = 1'b0;
   logic [ACC_W-1:0]  b_data = '0;
   logic              out_valid;
   logic [OW-1:0]     out_data;
   logic [15:0]       sat_cnt;

   always #5 clk = ~clk;

   conv_mac_nd #(
      .CH(CH), .K(K), .DW(DW), .WW(WW), .OW(OW), .SHIFT(SHIFT)
   ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .relu_en(relu_en), .sat_en(sat_en),
      .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
      .b_we(b_we), .b_data(b_data),
      .out_valid(out_valid), .out_data(out_data), .sat_cnt(sat_cnt)
   );

   typedef struct {
      logic [OW-1:0] d;
      int            sc;
      int            t;
   } exp_t;

   exp_t   sb[$];
   int     checks = 0;
   int     failures = 0;
   int     cyc = 0;
   int     wm[N];
   longint bm;
   int     msat;
   int     cur[N];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input longint act, input longint req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s: got %0d required %0d (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   // One cycle of stimulus; the sample (if any) sees the weights before
   // this cycle's write.
   task automatic drive(input bit v, input bit relu, input bit sat,
                        input bit we, input int addr, input int wd,
                        input bit bwe, input longint bd);
      exp_t   x;
      longint s;
      longint r;
      bit     clamp;
      @(negedge clk);
      in_valid = v;
      relu_en  = relu;
      sat_en   = sat;
      for (int e = 0; e < N; e++) in_data[e*DW +: DW] = DW'(cur[e]);
      w_we   = we;
      w_addr = AW'(addr);
      w_data = WW'(wd);
      b_we   = bwe;
      b_data = ACC_W'(bd);
      if (v) begin
         s = bm;
         for (int e = 0; e < N; e++) s += longint'(cur[e]) * longint'(wm[e]);
         r = s >>> SHIFT;
         if (relu && r < 0) r = 0;
         clamp = 1'b0;
         if (sat && r > OMAX) begin r = OMAX; clamp = 1'b1; end
         else if (sat && r < OMIN) begin r = OMIN; clamp = 1'b1; end
         if (clamp && msat < 65535) msat++;
         x.d  = r[OW-1:0];
         x.sc = msat;
         x.t  = cyc;
         sb.push_back(x);
      end
      if (we && addr < N) wm[addr] = wd;
      if (bwe) bm = bd;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() > 0 && n < 4*LAT) begin
         idle(1);
         n++;
      end
      check("drain_outstanding", sb.size(), 0);
      sb.delete();
      idle(2);
   endtask

   // Load every weight with wv; the last write optionally carries a bias write.
   task automatic load_all(input int wv, input bit bwe, input longint bd);
      for (int e = 0; e < N; e++) drive(0, 0, 0, 1, e, wv, (e == N-1) ? bwe : 1'b0, bd);
   endtask

   task automatic fill(input int v);
      for (int e = 0; e < N; e++) cur[e] = v;
   endtask

   task automatic fill_rand();
      for (int e = 0; e < N; e++) cur[e] = int'($urandom_range(4095)) - 2048;
   endtask

   // Monitor
   initial begin
      exp_t x;
      forever begin
         @(negedge clk);
         if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_out_valid: got pulse with out_data=%0d, required no pulse (cycle %0d)",
                        $signed(out_data), cyc);
            end else begin
               x = sb.pop_front();
               check("out_data", longint'($signed(out_data)), longint'($signed(x.d)));
               check("sat_cnt", longint'(sat_cnt), longint'(x.sc));
               check("latency", longint'(cyc - x.t), longint'(LAT));
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int pulses;
      for (int e = 0; e < N; e++) wm[e] = 0;
      bm   = 0;
      msat = 0;
      fill(0);

      // Reset and defaults
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset_out_valid", longint'(out_valid), 0);
      check("reset_out_data", longint'(out_data), 0);
      check("reset_sat_cnt", longint'(sat_cnt), 0);
      fill(100);
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      drain();

      // Basic MAC: weights 1, data 1024
      load_all(1, 0, 0);
      fill(1024);
      drive(1, 0, 1, 0, 0, 0, 0, 0);
      drain();

      // Sign and ReLU
      load_all(-1, 0, 0);
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      drive(1, 1, 0, 0, 0, 0, 0, 0);
      drain();
      load_all(0, 1, -1024);
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      drain();
      drive(0, 0, 0, 0, 0, 0, 1, -1);
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      drain();

      // Saturation vs wrap; bias cleared together with the last weight write
      load_all(127, 1, 0);
      fill(2047);
      drive(1, 0, 1, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      drain();

      // Streaming with a weight write in the cycle of sample 10
      for (int e = 0; e < N; e++) drive(0, 0, 0, 1, e, int'($urandom_range(255)) - 128, 0, 0);
      for (int i = 0; i < 20; i++) begin
         fill_rand();
         drive(1, 0, 0, (i == 9), 0, 2, 0, 0);
      end
      drain();

      // Randomised traffic with concurrent (sometimes out-of-range) weight writes
      drive(0, 0, 0, 0, 0, 0, 1, longint'(int'($urandom_range(1 << 24)) - (1 << 23)));
      for (int i = 0; i < 300; i++) begin
         fill_rand();
         drive(($urandom_range(9) < 7), $urandom_range(1), $urandom_range(1),
               ($urandom_range(9) < 3), int'($urandom_range(127)),
               int'($urandom_range(255)) - 128, 0, 0);
      end
      drain();

      // Saturating sums with sat_en to ensure sat_cnt is non-zero before reset
      load_all(127, 0, 0);
      fill(2047);
      drive(1, 0, 1, 0, 0, 0, 0, 0);
      drain();

      // Reset with samples in flight
      for (int i = 0; i < 5; i++) begin
         fill_rand();
         drive(1, $urandom_range(1), 1, 0, 0, 0, 0, 0);
      end
      @(negedge clk);
      in_valid = 1'b0;
      rst      = 1'b1;
      sb.delete();
      for (int e = 0; e < N; e++) wm[e] = 0;
      bm   = 0;
      msat = 0;
      @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      for (int i = 0; i < 3*LAT; i++) begin
         idle(1);
         if (out_valid) pulses++;
      end
      check("post_reset_pulses", pulses, 0);
      check("post_reset_out_data", longint'(out_data), 0);
      check("post_reset_sat_cnt", longint'(sat_cnt), 0);
      fill_rand();
      drive(1, 0, 1, 0, 0, 0, 0, 0);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
